ps2_key_ctrl: RTL and testbench



---
 rtl/ps2_key_ctrl_if.sv | 37 +++
 rtl/ps2_key_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_ctrl_if
//  Description : Bundle of the PS2 key controller's frame input, event
//                stream and status signals.
//                  i_frame_valid / i_frame   : raw 11-bit frame strobe in
//                  o_evt_valid / i_evt_ready / o_evt : event FIFO head
//                  o_status_stb / o_status_byte      : device status bytes
//                  o_overflow / o_err_cnt / i_clr_status : error reporting
//                master = producer/consumer side, slave = controller side.
//  Revision    : 1.0  initial release
// ============================================================================
interface ps2_key_ctrl_if;
    logic        i_frame_valid;
    logic [10:0] i_frame;
    logic        o_evt_valid;
    logic        i_evt_ready;
    logic [9:0]  o_evt;
    logic        o_status_stb;
    logic [7:0]  o_status_byte;
    logic        o_overflow;
    logic [7:0]  o_err_cnt;
    logic        i_clr_status;

    modport master (
        output i_frame_valid, i_frame, i_evt_ready, i_clr_status,
        input  o_evt_valid, o_evt, o_status_stb, o_status_byte,
               o_overflow, o_err_cnt
    );

    modport slave (
        input  i_frame_valid, i_frame, i_evt_ready, i_clr_status,
        output o_evt_valid, o_evt, o_status_stb, o_status_byte,
               o_overflow, o_err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_ctrl
//  Description : PS2 keyboard byte sequencer. Validates 11-bit frames, folds
//                E0/F0 prefixes into {ext, brk, code} events, separates
//                device status bytes, and queues events in a small FIFO.
//                A watchdog drops stale prefixes.
//  Ports       : i_clk  - system clock
//                i_rst  - asynchronous active-high reset
//                bus    - ps2_key_ctrl_if.slave (frame in, events, status)
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_key_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input wire logic       i_clk,
    input wire logic       i_rst,
    ps2_key_ctrl_if.slave  bus
);

    localparam int          c_AW       = $clog2(FIFO_DEPTH);
    localparam int          c_CW       = c_AW + 1;
    localparam logic [19:0] c_TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_E0   = 2'd1,
        ST_F0   = 2'd2,
        ST_E0F0 = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [19:0]     r_timer;
    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_status_stb;
    logic [7:0]      r_status_byte;
    logic            r_overflow;
    logic [7:0]      r_err_cnt;

    logic [7:0] w_byte;
    logic       w_good;
    logic       w_is_e0, w_is_f0, w_is_status;
    logic       w_timeout;
    logic       w_evt_push;
    logic [9:0] w_evt_data;
    logic       w_err_inc;
    logic       w_status_hit;
    logic       w_full, w_empty, w_pop, w_push, w_drop;

    // ------------------------------------------------------------------------
    // Frame check: start=0, stop=1, odd parity over data+parity bits
    // ------------------------------------------------------------------------
    assign w_byte      = bus.i_frame[8:1];
    assign w_good      = ~bus.i_frame[0] & bus.i_frame[10] & (^bus.i_frame[9:1]);
    assign w_is_e0     = (w_byte == 8'hE0);
    assign w_is_f0     = (w_byte == 8'hF0);
    assign w_is_status = (w_byte == 8'hFA) || (w_byte == 8'hAA) ||
                         (w_byte == 8'hEE) || (w_byte == 8'hFE);

    // A strobe in the expiry cycle takes priority over the timeout.
    assign w_timeout = (r_state != ST_IDLE) && (r_timer == c_TMO_LAST) &&
                       !bus.i_frame_valid;

    // ------------------------------------------------------------------------
    // Prefix decoder FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_evt_push   = 1'b0;
        w_evt_data   = 10'd0;
        w_err_inc    = 1'b0;
        w_status_hit = 1'b0;
        if (bus.i_frame_valid) begin
            if (!w_good) begin
                w_state_nxt = ST_IDLE;
                w_err_inc   = 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_is_e0)          w_state_nxt  = ST_E0;
                        else if (w_is_f0)     w_state_nxt  = ST_F0;
                        else if (w_is_status) w_status_hit = 1'b1;
                        else begin
                            w_evt_push = 1'b1;
                            w_evt_data = {2'b00, w_byte};
                        end
                    end
                    ST_E0: begin
                        // Repeated E0 keeps the extended prefix pending.
                        if (w_is_f0)      w_state_nxt = ST_E0F0;
                        else if (w_is_e0) w_state_nxt = ST_E0;
                        else begin
                            w_state_nxt = ST_IDLE;
                            w_evt_push  = 1'b1;
                            w_evt_data  = {2'b10, w_byte};
                        end
                    end
                    ST_F0: begin
                        w_state_nxt = ST_IDLE;
                        if (w_is_e0 || w_is_f0) w_err_inc = 1'b1;
                        else begin
                            w_evt_push = 1'b1;
                            w_evt_data = {2'b01, w_byte};
                        end
                    end
                    default: begin // ST_E0F0
                        w_state_nxt = ST_IDLE;
                        if (w_is_e0 || w_is_f0) w_err_inc = 1'b1;
                        else begin
                            w_evt_push = 1'b1;
                            w_evt_data = {2'b11, w_byte};
                        end
                    end
                endcase
            end
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_err_inc   = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Prefix watchdog: only counts while a prefix is pending
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                   r_timer <= 20'd0;
        else if (bus.i_frame_valid)  r_timer <= 20'd0;
        else if (w_timeout)          r_timer <= 20'd0;
        else if (r_state != ST_IDLE) r_timer <= r_timer + 20'd1;
        else                         r_timer <= 20'd0;
    end

    // ------------------------------------------------------------------------
    // Event FIFO: a pop in the same cycle frees the slot for a push when full
    // ------------------------------------------------------------------------
    assign w_full  = (r_count == c_CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & bus.i_evt_ready;
    assign w_push  = w_evt_push & (~w_full | w_pop);
    assign w_drop  = w_evt_push & w_full & ~w_pop;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 10'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_evt_data;
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Status byte, overflow and error reporting; a clear beats a new error
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_status_stb  <= 1'b0;
            r_status_byte <= 8'd0;
            r_overflow    <= 1'b0;
            r_err_cnt     <= 8'd0;
        end else begin
            r_status_stb <= w_status_hit;
            if (w_status_hit) r_status_byte <= w_byte;
            if (bus.i_clr_status) begin
                r_overflow <= 1'b0;
                r_err_cnt  <= 8'd0;
            end else begin
                if (w_drop) r_overflow <= 1'b1;
                if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign bus.o_evt_valid   = ~w_empty;
    assign bus.o_evt         = r_mem[r_rd_ptr];
    assign bus.o_status_stb  = r_status_stb;
    assign bus.o_status_byte = r_status_byte;
    assign bus.o_overflow    = r_overflow;
    assign bus.o_err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_ctrl
//  Description : Self-checking bench for ps2_key_ctrl. Table of frames with
//                expected error count / status pulse, event scoreboard queue,
//                plus sequences for timeout, overflow, clear and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_key_ctrl;

    localparam int c_DEPTH = 4;
    localparam int c_TMO   = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_key_ctrl_if bus ();

    ps2_key_ctrl #(
        .FIFO_DEPTH     (c_DEPTH),
        .TIMEOUT_CYCLES (c_TMO)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [9:0] exp_q [$];

    typedef struct {
        logic [10:0] frame;
        bit          has_evt;
        logic [9:0]  evt;
        logic [7:0]  err;
        bit          stb;
    } vec_t;
    vec_t vq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // kind: 0 good, 1 bad parity, 2 bad start, 3 bad stop
    function automatic logic [10:0] mk(input logic [7:0] b, input int kind);
        logic p;
        p = ~(^b);
        if (kind == 1) p = ~p;
        return {(kind == 3) ? 1'b0 : 1'b1, p, b, (kind == 2) ? 1'b1 : 1'b0};
    endfunction

    task automatic add(input logic [10:0] f, input bit he, input logic [9:0] e,
                       input logic [7:0] er, input bit s);
        vec_t v;
        v.frame = f; v.has_evt = he; v.evt = e; v.err = er; v.stb = s;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [10:0] f);
        bus.i_frame       = f;
        bus.i_frame_valid = 1'b1;
        tick();
        bus.i_frame_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    // Scoreboard: a transfer happens on the next edge whenever valid&ready.
    always @(negedge clk) begin
        if (!rst && bus.o_evt_valid && bus.i_evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL evt_unexpected: got %0h expected none", bus.o_evt);
            end else begin
                chk("evt", bus.o_evt, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus.i_frame_valid = 1'b0;
        bus.i_frame       = 11'd0;
        bus.i_evt_ready   = 1'b0;
        bus.i_clr_status  = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_evt_valid", bus.o_evt_valid, 0);
        chk("rst_evt", bus.o_evt, 0);
        chk("rst_stb", bus.o_status_stb, 0);
        chk("rst_status_byte", bus.o_status_byte, 0);
        chk("rst_overflow", bus.o_overflow, 0);
        chk("rst_err", bus.o_err_cnt, 0);
        rst = 1'b0;
        tick();

        // One-cycle latency
        send(mk(8'h1C, 0));
        exp_q.push_back(10'h01C);
        chk("latency_valid", bus.o_evt_valid, 1);
        bus.i_evt_ready = 1'b1;

        // Table of frames
        add(mk(8'h1C,0), 1, 10'h01C, 0, 0);
        add(mk(8'hE0,0), 0, 0,       0, 0);
        add(mk(8'h75,0), 1, 10'h275, 0, 0);
        add(mk(8'hF0,0), 0, 0,       0, 0);
        add(mk(8'h1C,0), 1, 10'h11C, 0, 0);
        add(mk(8'hE0,0), 0, 0,       0, 0);
        add(mk(8'hF0,0), 0, 0,       0, 0);
        add(mk(8'h75,0), 1, 10'h375, 0, 0);
        add(mk(8'h1C,1), 0, 0,       1, 0);
        add(mk(8'h1C,0), 1, 10'h01C, 1, 0);
        add(mk(8'hAA,0), 0, 0,       1, 1);
        add(mk(8'hFA,0), 0, 0,       1, 1);
        add(mk(8'hF0,0), 0, 0,       1, 0);
        add(mk(8'hE0,0), 0, 0,       2, 0);
        add(mk(8'hE0,0), 0, 0,       2, 0);
        add(mk(8'hE0,0), 0, 0,       2, 0);
        add(mk(8'h74,0), 1, 10'h274, 2, 0);
        add(mk(8'hE0,0), 0, 0,       2, 0);
        add(mk(8'hFA,0), 1, 10'h2FA, 2, 0);
        add(mk(8'h1C,3), 0, 0,       3, 0);
        add(mk(8'h1C,2), 0, 0,       4, 0);
        add(mk(8'hE0,0), 0, 0,       4, 0);
        add(mk(8'hF0,0), 0, 0,       4, 0);
        add(mk(8'hF0,0), 0, 0,       5, 0);
        add(mk(8'hEE,0), 0, 0,       5, 1);
        add(mk(8'hF0,0), 0, 0,       5, 0);
        add(mk(8'hFE,0), 1, 10'h1FE, 5, 0);

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].has_evt) exp_q.push_back(vq[i].evt);
            send(vq[i].frame);
            chk($sformatf("vec%0d_err", i), bus.o_err_cnt, vq[i].err);
            chk($sformatf("vec%0d_stb", i), bus.o_status_stb, vq[i].stb);
            if (vq[i].stb)
                chk($sformatf("vec%0d_sbyte", i), bus.o_status_byte, vq[i].frame[8:1]);
        end
        drain(20);

        // Clear, then clear colliding with a bad frame
        bus.i_clr_status = 1'b1;
        tick();
        chk("clr_err", bus.o_err_cnt, 0);
        chk("clr_ovf", bus.o_overflow, 0);
        send(mk(8'h1C, 1));
        bus.i_clr_status = 1'b0;
        chk("clr_wins_err", bus.o_err_cnt, 0);

        // Stale prefix expires
        send(mk(8'hE0, 0));
        repeat (c_TMO) tick();
        exp_q.push_back(10'h075);
        send(mk(8'h75, 0));
        chk("timeout_err", bus.o_err_cnt, 1);
        drain(20);

        // Strobe in the expiry cycle wins
        send(mk(8'hE0, 0));
        repeat (c_TMO - 1) tick();
        exp_q.push_back(10'h275);
        send(mk(8'h75, 0));
        chk("tmo_edge_err", bus.o_err_cnt, 1);
        drain(20);

        // Overflow: five codes into a four-deep FIFO
        bus.i_clr_status = 1'b1;
        tick();
        bus.i_clr_status = 1'b0;
        bus.i_evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < c_DEPTH) exp_q.push_back(10'(8'h10 + i));
            send(mk(8'(8'h10 + i), 0));
        end
        chk("ovf_set", bus.o_overflow, 1);
        chk("ovf_valid", bus.o_evt_valid, 1);
        chk("ovf_head", bus.o_evt, 10'h010);
        bus.i_evt_ready = 1'b1;
        drain(20);
        chk("ovf_empty", bus.o_evt_valid, 0);

        // Full FIFO, push and pop in the same cycle
        bus.i_clr_status = 1'b1;
        tick();
        bus.i_clr_status = 1'b0;
        bus.i_evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(10'(8'h20 + i));
            send(mk(8'(8'h20 + i), 0));
        end
        chk("full_no_ovf", bus.o_overflow, 0);
        bus.i_evt_ready = 1'b1;
        exp_q.push_back(10'h024);
        send(mk(8'h24, 0));
        bus.i_evt_ready = 1'b0;
        chk("pushpop_no_ovf", bus.o_overflow, 0);
        send(mk(8'h25, 0));
        chk("still_full_ovf", bus.o_overflow, 1);
        bus.i_evt_ready = 1'b1;
        drain(20);
        chk("pushpop_empty", bus.o_evt_valid, 0);

        // Reset mid-sequence drops queued events and pending prefixes
        bus.i_evt_ready = 1'b0;
        send(mk(8'h33, 0));
        send(mk(8'hE0, 0));
        send(mk(8'hF0, 0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", bus.o_evt_valid, 0);
        chk("midrst_ovf", bus.o_overflow, 0);
        bus.i_evt_ready = 1'b1;
        exp_q.push_back(10'h075);
        send(mk(8'h75, 0));
        drain(20);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
